// File: rtl/sysid_boot_checker.sv
// sysid_boot_checker: reads the system-ID slave, verifies ID and timestamp,
// retries on mismatch or stall, and gates the motor drive on a verified match.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0400_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5466_A26B,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter int          READ_LATENCY       = 1,
  parameter int          MAX_RETRIES        = 3,
  parameter int          RETRY_DELAY        = 1000,
  parameter int          WAIT_TIMEOUT       = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        pass,
  output logic        fail,
  output logic        motor_enable,
  output logic [31:0] captured_id,
  output logic [31:0] captured_timestamp,
  output logic [3:0]  attempt_count
);

  typedef enum logic [3:0] {
    ST_BOOT,
    ST_RD_ID,
    ST_LAT_ID,
    ST_RD_TS,
    ST_LAT_TS,
    ST_CHECK,
    ST_RETRY,
    ST_PASS,
    ST_FAIL
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic [3:0]  att_q, att_d;
  logic        tmo_q, tmo_d;

  logic accept;
  logic expired;
  logic lat_done;
  logic match;
  logic can_retry;

  assign accept   = avm_read && !avm_waitrequest;
  assign expired  = avm_waitrequest &&
                    (cnt_q == 32'(WAIT_TIMEOUT - 1));
  assign lat_done = (cnt_q == 32'(READ_LATENCY - 1));
  assign match    = (id_q == EXPECTED_ID) &&
                    (!CHECK_TIMESTAMP ||
                     ts_q == EXPECTED_TIMESTAMP);
  assign can_retry = (32'(att_q) <= 32'(MAX_RETRIES));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_BOOT;
      cnt_q   <= '0;
      id_q    <= '0;
      ts_q    <= '0;
      att_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      att_q   <= att_d;
      tmo_q   <= tmo_d;
    end
  end

  // One counter serves wait timeout, read latency and retry delay;
  // it is cleared on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    id_d    = id_q;
    ts_d    = ts_q;
    att_d   = att_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RD_ID;
        att_d   = 4'd1;
        tmo_d   = 1'b0;
        cnt_d   = '0;
      end
      ST_RD_ID: begin
        if (accept) begin
          cnt_d = '0;
          if (READ_LATENCY == 0) begin
            id_d    = avm_readdata;
            state_d = ST_RD_TS;
          end else begin
            state_d = ST_LAT_ID;
          end
        end else if (expired) begin
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_CHECK;
        end
      end
      ST_LAT_ID: begin
        if (lat_done) begin
          id_d    = avm_readdata;
          cnt_d   = '0;
          state_d = ST_RD_TS;
        end
      end
      ST_RD_TS: begin
        if (accept) begin
          cnt_d = '0;
          if (READ_LATENCY == 0) begin
            ts_d    = avm_readdata;
            state_d = ST_CHECK;
          end else begin
            state_d = ST_LAT_TS;
          end
        end else if (expired) begin
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_CHECK;
        end
      end
      ST_LAT_TS: begin
        if (lat_done) begin
          ts_d    = avm_readdata;
          cnt_d   = '0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        cnt_d = '0;
        if (match && !tmo_q) begin
          state_d = ST_PASS;
        end else if (can_retry) begin
          state_d = ST_RETRY;
        end else begin
          state_d = ST_FAIL;
        end
      end
      ST_RETRY: begin
        if (cnt_q == 32'(RETRY_DELAY - 1)) begin
          cnt_d   = '0;
          tmo_d   = 1'b0;
          state_d = ST_RD_ID;
          att_d   = (att_q == 4'hF) ? 4'hF
                                    : att_q + 4'd1;
        end
      end
      ST_PASS, ST_FAIL: begin
        cnt_d = '0;
        if (start) begin
          state_d = ST_RD_ID;
          att_d   = 4'd1;
          tmo_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_BOOT;
        cnt_d   = '0;
      end
    endcase
  end

  assign avm_read    = (state_q == ST_RD_ID) ||
                       (state_q == ST_RD_TS);
  assign avm_address = (state_q == ST_RD_TS) ||
                       (state_q == ST_LAT_TS);
  assign busy        = (state_q != ST_BOOT) &&
                       (state_q != ST_PASS) &&
                       (state_q != ST_FAIL);
  assign pass         = (state_q == ST_PASS);
  assign fail         = (state_q == ST_FAIL);
  assign motor_enable = pass;

  assign captured_id        = id_q;
  assign captured_timestamp = ts_q;
  assign attempt_count      = att_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// tb_sysid_boot_checker: two checker instances with different build
// parameters, each served by its own Avalon slave model.
module tb_sysid_boot_checker;

  localparam logic [31:0] EID  = 32'h0400_0000;
  localparam logic [31:0] ETS  = 32'h5466_A26B;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
  localparam int          WT   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start = 1'b0;

  logic [1:0]       rd, addr, wr, busy, pas, fal, me;
  logic [1:0][31:0] rdata, cid, cts;
  logic [1:0][3:0]  att;
  logic [1:0][31:0] id_v, ts_v;
  logic [1:0]       stuck = 2'b00;
  int               nwait [2] = '{0, 0};

  int   cyc = 0;
  int   wcnt [2] = '{0, 0};
  int   lcnt [2] = '{0, 0};
  logic la   [2] = '{1'b0, 1'b0};
  int   nacc [2] = '{0, 0};
  int   rdcyc[2] = '{0, 0};

  int         done_cyc[2] = '{0, 0};
  int         stab_err[2] = '{0, 0};
  int         both_err[2] = '{0, 0};
  logic [1:0] busy_p = 2'b00;
  logic [1:0] rd_p = 2'b00;
  logic [1:0] wr_p = 2'b00;
  logic [1:0] addr_p = 2'b00;

  logic [31:0] m_cid[2];
  logic [31:0] m_cts[2];

  int checks = 0;
  int errors = 0;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 2;
  endfunction
  function automatic int ct_of(input int g);
    return (g == 0) ? 1 : 0;
  endfunction
  function automatic int mr_of(input int g);
    return (g == 0) ? 2 : 0;
  endfunction
  function automatic int dly_of(input int g);
    return (g == 0) ? 4 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sysid_boot_checker #(
      .CHECK_TIMESTAMP(g == 0),
      .READ_LATENCY   (g == 0 ? 1 : 2),
      .MAX_RETRIES    (g == 0 ? 2 : 0),
      .RETRY_DELAY    (g == 0 ? 4 : 3),
      .WAIT_TIMEOUT   (WT)
    ) u_dut (
      .clock             (clk),
      .reset             (rst),
      .start             (start),
      .avm_address       (addr[g]),
      .avm_read          (rd[g]),
      .avm_waitrequest   (wr[g]),
      .avm_readdata      (rdata[g]),
      .busy              (busy[g]),
      .pass              (pas[g]),
      .fail              (fal[g]),
      .motor_enable      (me[g]),
      .captured_id       (cid[g]),
      .captured_timestamp(cts[g]),
      .attempt_count     (att[g])
    );
  end

  // Slave: stall for nwait cycles per read, then return data only on
  // the exact sample cycle; any other cycle returns junk.
  always_comb begin
    for (int g = 0; g < 2; g++)
      wr[g] = stuck[g] | (rd[g] & (wcnt[g] < nwait[g]));
  end

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      rdata[g] = JUNK;
      if (lat_of(g) == 0) begin
        if (rd[g] && !wr[g])
          rdata[g] = addr[g] ? ts_v[g] : id_v[g];
      end else if (lcnt[g] == lat_of(g)) begin
        rdata[g] = la[g] ? ts_v[g] : id_v[g];
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 2; g++) begin
      wcnt[g] <= (rd[g] && wr[g]) ? wcnt[g] + 1 : 0;
      if (rd[g] && !rst) rdcyc[g] <= rdcyc[g] + 1;
      if (rd[g] && !wr[g] && !rst) begin
        nacc[g] <= nacc[g] + 1;
        la[g]   <= addr[g];
        lcnt[g] <= 1;
      end else if (lcnt[g] != 0 && lcnt[g] < 8) begin
        lcnt[g] <= lcnt[g] + 1;
      end else begin
        lcnt[g] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (busy_p[g] && !busy[g]) done_cyc[g] <= cyc;
      if (pas[g] && fal[g]) both_err[g] <= both_err[g] + 1;
      if (me[g] !== pas[g]) both_err[g] <= both_err[g] + 1;
      if (rd[g] && !busy[g]) stab_err[g] <= stab_err[g] + 1;
      if (rd_p[g] && wr_p[g] && rd[g] && addr[g] !== addr_p[g])
        stab_err[g] <= stab_err[g] + 1;
    end
    busy_p <= busy;
    rd_p   <= rd;
    wr_p   <= wr;
    addr_p <= addr;
  end

  function automatic bit exp_match(input int g,
                                   input logic [31:0] id,
                                   input logic [31:0] ts);
    return (id == EID) && (ct_of(g) == 0 || ts == ETS);
  endfunction

  function automatic int exp_att(input int g, input bit m);
    return m ? 1 : mr_of(g) + 1;
  endfunction

  function automatic int exp_cyc(input int g, input bit m,
                                 input int n, input bit stk);
    int a;
    int per;
    a   = exp_att(g, m && !stk);
    per = stk ? WT + 1 : 2 * (n + 1 + lat_of(g)) + 1;
    return 1 + a * per + (a - 1) * dly_of(g);
  endfunction

  function automatic int exp_rdc(input int g, input bit m,
                                 input int n, input bit stk);
    int a;
    a = exp_att(g, m && !stk);
    return stk ? a * WT : a * 2 * (n + 1);
  endfunction

  task automatic set_slave(input logic [31:0] id,
                           input logic [31:0] ts,
                           input int n);
    for (int g = 0; g < 2; g++) begin
      id_v[g]  = id;
      ts_v[g]  = ts;
      nwait[g] = n;
      stuck[g] = 1'b0;
    end
  endtask

  task automatic wait_idle(output bit to);
    to = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (!busy[0] && !busy[1]) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    #1;
  endtask

  task automatic launch(input bit use_rst,
                        output int k, output bit to);
    @(negedge clk);
    if (use_rst) begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        m_cid[g] = '0;
        m_cts[g] = '0;
      end
      rst = 1'b0;
      k = cyc;
    end else begin
      start = 1'b1;
      k = cyc;
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle(to);
    for (int g = 0; g < 2; g++) begin
      if (!stuck[g]) begin
        m_cid[g] = id_v[g];
        m_cts[g] = ts_v[g];
      end
    end
  endtask

  task automatic test_reset();
    set_slave(EID, ETS, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({rd[g], addr[g], busy[g], pas[g], fal[g], me[g]} !== 6'b0
          || cid[g] !== 32'h0 || cts[g] !== 32'h0
          || att[g] !== 4'h0) begin
        errors++;
        $display("FAIL reset g%0d got rd%b a%b b%b p%b f%b m%b %h %h %h exp all 0",
                 g, rd[g], addr[g], busy[g], pas[g], fal[g], me[g],
                 cid[g], cts[g], att[g]);
      end
    end
  endtask

  task automatic test_basic();
    int k;
    bit to;
    set_slave(EID, ETS, 0);
    launch(1'b1, k, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout got busy exp idle"); end
    checks++;
    if (done_cyc[0] - k !== 6) begin
      errors++;
      $display("FAIL basic_lat got %0d exp 6", done_cyc[0] - k);
    end
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({pas[g], me[g], busy[g], fal[g]} !== 4'b1100) begin
        errors++;
        $display("FAIL basic_flags g%0d got %b exp 1100", g,
                 {pas[g], me[g], busy[g], fal[g]});
      end
      checks++;
      if (att[g] !== 4'd1 || cid[g] !== EID || cts[g] !== ETS) begin
        errors++;
        $display("FAIL basic_cap g%0d got %h %h %h exp 1 %h %h",
                 g, att[g], cid[g], cts[g], EID, ETS);
      end
    end
    checks++;
    if (done_cyc[1] - k !== exp_cyc(1, 1, 0, 0)) begin
      errors++;
      $display("FAIL basic_lat1 got %0d exp %0d",
               done_cyc[1] - k, exp_cyc(1, 1, 0, 0));
    end
  endtask

  task automatic test_retry();
    int k;
    bit to;
    int n0;
    set_slave(EID, ETS, 0);
    id_v[0] = 32'h0400_0001;
    n0 = nacc[0];
    launch(1'b0, k, to);
    checks++;
    if (to) begin errors++; $display("FAIL retry_timeout got busy exp idle"); end
    checks++;
    if ({fal[0], pas[0], me[0]} !== 3'b100 || att[0] !== 4'd3) begin
      errors++;
      $display("FAIL retry_flags got %b att %0d exp 100 att 3",
               {fal[0], pas[0], me[0]}, att[0]);
    end
    checks++;
    if (cid[0] !== 32'h0400_0001) begin
      errors++;
      $display("FAIL retry_cid got %h exp 04000001", cid[0]);
    end
    checks++;
    if (nacc[0] - n0 !== 6) begin
      errors++;
      $display("FAIL retry_reads got %0d exp 6", nacc[0] - n0);
    end
    checks++;
    if (done_cyc[0] - k !== 24) begin
      errors++;
      $display("FAIL retry_lat got %0d exp 24", done_cyc[0] - k);
    end
    checks++;
    if (pas[1] !== 1'b1) begin
      errors++;
      $display("FAIL retry_g1 got %b exp 1", pas[1]);
    end
  endtask

  task automatic test_timeout();
    int k;
    bit to;
    int r0[2];
    int n0[2];
    set_slave(EID, ETS, 0);
    stuck = 2'b11;
    for (int g = 0; g < 2; g++) begin
      r0[g] = rdcyc[g];
      n0[g] = nacc[g];
    end
    launch(1'b0, k, to);
    checks++;
    if (to) begin errors++; $display("FAIL tmo_timeout got busy exp idle"); end
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({fal[g], pas[g]} !== 2'b10 ||
          att[g] !== 4'(exp_att(g, 0))) begin
        errors++;
        $display("FAIL tmo_flags g%0d got %b att %0d exp 10 att %0d",
                 g, {fal[g], pas[g]}, att[g], exp_att(g, 0));
      end
      checks++;
      if (rdcyc[g] - r0[g] !== exp_rdc(g, 0, 0, 1) ||
          nacc[g] !== n0[g]) begin
        errors++;
        $display("FAIL tmo_rd g%0d got %0d/%0d exp %0d/0", g,
                 rdcyc[g] - r0[g], nacc[g] - n0[g], exp_rdc(g, 0, 0, 1));
      end
      checks++;
      if (done_cyc[g] - k !== exp_cyc(g, 0, 0, 1) ||
          cid[g] !== m_cid[g]) begin
        errors++;
        $display("FAIL tmo_lat g%0d got %0d %h exp %0d %h", g,
                 done_cyc[g] - k, cid[g], exp_cyc(g, 0, 0, 1), m_cid[g]);
      end
    end
    stuck = 2'b00;
  endtask

  task automatic test_waits();
    int k;
    bit to;
    int n0[2];
    set_slave(EID, ETS, 5);
    for (int g = 0; g < 2; g++) n0[g] = nacc[g];
    launch(1'b0, k, to);
    checks++;
    if (to) begin errors++; $display("FAIL wait_timeout got busy exp idle"); end
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (pas[g] !== 1'b1 || nacc[g] - n0[g] !== 2) begin
        errors++;
        $display("FAIL wait_pass g%0d got %b reads %0d exp 1 reads 2",
                 g, pas[g], nacc[g] - n0[g]);
      end
      checks++;
      if (done_cyc[g] - k !== exp_cyc(g, 1, 5, 0)) begin
        errors++;
        $display("FAIL wait_lat g%0d got %0d exp %0d", g,
                 done_cyc[g] - k, exp_cyc(g, 1, 5, 0));
      end
    end
  endtask

  task automatic test_ts();
    int k;
    bit to;
    set_slave(EID, 32'h5466_A26C, 0);
    launch(1'b0, k, to);
    checks++;
    if (to) begin errors++; $display("FAIL ts_timeout got busy exp idle"); end
    checks++;
    if ({fal[0], pas[0]} !== 2'b10) begin
      errors++;
      $display("FAIL ts_chk got %b exp 10", {fal[0], pas[0]});
    end
    checks++;
    if ({fal[1], pas[1]} !== 2'b01 || cts[1] !== 32'h5466_A26C) begin
      errors++;
      $display("FAIL ts_nochk got %b %h exp 01 5466a26c",
               {fal[1], pas[1]}, cts[1]);
    end
  endtask

  task automatic test_restart();
    int k;
    bit to;
    int n0[2];
    set_slave(EID, ETS, 0);
    launch(1'b0, k, to);
    checks++;
    if (pas !== 2'b11) begin
      errors++;
      $display("FAIL rs_pre got %b exp 11", pas);
    end
    set_slave(32'h1234_5678, ETS, 0);
    for (int g = 0; g < 2; g++) n0[g] = nacc[g];
    start = 1'b1;
    k = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({me[g], pas[g], busy[g]} !== 3'b001 || att[g] !== 4'd1) begin
        errors++;
        $display("FAIL rs_kick g%0d got %b att %0d exp 001 att 1", g,
                 {me[g], pas[g], busy[g]}, att[g]);
      end
    end
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(to);
    checks++;
    if (to) begin errors++; $display("FAIL rs_timeout got busy exp idle"); end
    for (int g = 0; g < 2; g++) begin
      m_cid[g] = id_v[g];
      m_cts[g] = ts_v[g];
      checks++;
      if (fal[g] !== 1'b1 || nacc[g] - n0[g] !== 2 * exp_att(g, 0)) begin
        errors++;
        $display("FAIL rs_end g%0d got %b reads %0d exp 1 reads %0d", g,
                 fal[g], nacc[g] - n0[g], 2 * exp_att(g, 0));
      end
      checks++;
      if (done_cyc[g] - k !== exp_cyc(g, 0, 0, 0)) begin
        errors++;
        $display("FAIL rs_lat g%0d got %0d exp %0d", g,
                 done_cyc[g] - k, exp_cyc(g, 0, 0, 0));
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    bit to;
    set_slave(EID, ETS, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({rd[g], addr[g], busy[g], pas[g], fal[g], me[g]} !== 6'b0
          || cid[g] !== 32'h0 || cts[g] !== 32'h0
          || att[g] !== 4'h0) begin
        errors++;
        $display("FAIL mid_rst g%0d got rd%b b%b p%b f%b %h %h %h exp all 0",
                 g, rd[g], busy[g], pas[g], fal[g], cid[g], cts[g], att[g]);
      end
    end
    rst = 1'b0;
    k = cyc;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({busy[g], rd[g], addr[g]} !== 3'b110 || att[g] !== 4'd1) begin
        errors++;
        $display("FAIL mid_restart g%0d got %b att %0d exp 110 att 1",
                 g, {busy[g], rd[g], addr[g]}, att[g]);
      end
    end
    wait_idle(to);
    checks++;
    if (to) begin errors++; $display("FAIL mid_timeout got busy exp idle"); end
    for (int g = 0; g < 2; g++) begin
      m_cid[g] = EID;
      m_cts[g] = ETS;
      checks++;
      if (pas[g] !== 1'b1 || att[g] !== 4'd1 ||
          done_cyc[g] - k !== exp_cyc(g, 1, 0, 0)) begin
        errors++;
        $display("FAIL mid_end g%0d got %b %0d %0d exp 1 1 %0d", g,
                 pas[g], att[g], done_cyc[g] - k, exp_cyc(g, 1, 0, 0));
      end
    end
  endtask

  task automatic test_random(input int iters);
    int  k;
    bit  to;
    bit  m;
    int  a;
    int  n0[2];
    int  r0[2];
    for (int it = 0; it < iters; it++) begin
      for (int g = 0; g < 2; g++) begin
        id_v[g] = ($urandom_range(0, 2) == 0) ?
                  (EID ^ (32'd1 << $urandom_range(0, 31))) : EID;
        ts_v[g] = ($urandom_range(0, 2) == 0) ?
                  (ETS ^ (32'd1 << $urandom_range(0, 31))) : ETS;
        nwait[g] = $urandom_range(0, 5);
        stuck[g] = ($urandom_range(0, 7) == 0);
        n0[g] = nacc[g];
        r0[g] = rdcyc[g];
      end
      launch(it % 4 == 0, k, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL rnd_timeout it%0d got busy exp idle", it);
      end
      for (int g = 0; g < 2; g++) begin
        m = exp_match(g, id_v[g], ts_v[g]) && !stuck[g];
        a = exp_att(g, m);
        checks++;
        if ({pas[g], fal[g], me[g], busy[g]} !== {m, !m, m, 1'b0} ||
            att[g] !== 4'(a)) begin
          errors++;
          $display("FAIL rnd_flags it%0d g%0d got %b %0d exp %b %0d",
                   it, g, {pas[g], fal[g], me[g], busy[g]}, att[g],
                   {m, !m, m, 1'b0}, a);
        end
        checks++;
        if (cid[g] !== m_cid[g] || cts[g] !== m_cts[g]) begin
          errors++;
          $display("FAIL rnd_cap it%0d g%0d got %h %h exp %h %h", it, g,
                   cid[g], cts[g], m_cid[g], m_cts[g]);
        end
        checks++;
        if (done_cyc[g] - k !== exp_cyc(g, m, nwait[g], stuck[g])) begin
          errors++;
          $display("FAIL rnd_lat it%0d g%0d got %0d exp %0d", it, g,
                   done_cyc[g] - k, exp_cyc(g, m, nwait[g], stuck[g]));
        end
        checks++;
        if (nacc[g] - n0[g] !== (stuck[g] ? 0 : 2 * a) ||
            rdcyc[g] - r0[g] !== exp_rdc(g, m, nwait[g], stuck[g])) begin
          errors++;
          $display("FAIL rnd_rd it%0d g%0d got %0d/%0d exp %0d/%0d", it, g,
                   nacc[g] - n0[g], rdcyc[g] - r0[g],
                   stuck[g] ? 0 : 2 * a,
                   exp_rdc(g, m, nwait[g], stuck[g]));
        end
      end
    end
    stuck = 2'b00;
  endtask

  task automatic test_invariants();
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (stab_err[g] !== 0) begin
        errors++;
        $display("FAIL bus_rules g%0d got %0d exp 0", g, stab_err[g]);
      end
      checks++;
      if (both_err[g] !== 0) begin
        errors++;
        $display("FAIL flag_rules g%0d got %0d exp 0", g, both_err[g]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_retry();
    test_waits();
    test_timeout();
    test_ts();
    test_restart();
    test_reset_mid();
    test_random(30);
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
